// File: rtl/mem_rd_req_gen.sv
// Read-request generator: walks a descriptor ROM and issues strided read
// requests (base + k*stride, k = 0..loop_max) to the read channel.
module mem_rd_req_gen #(
  parameter int ADDR_W        = 32,
  parameter int BASE_ADDR_W   = ADDR_W,
  parameter int OFFSET_ADDR_W = ADDR_W,
  parameter int TX_SIZE_WIDTH = 20,
  parameter int RD_LOOP_W     = 10,
  parameter int D_TYPE_W      = 1,
  parameter int ROM_ADDR_W    = 6,
  localparam int ROM_WIDTH    = D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W + TX_SIZE_WIDTH + RD_LOOP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROM_ADDR_W:0]      cfg_count,
  output logic                     done,
  output logic                     cfg_rd_en,
  output logic [ROM_ADDR_W-1:0]    cfg_addr,
  input  logic [ROM_WIDTH-1:0]     cfg_data,
  input  logic                     rd_ready,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic [D_TYPE_W-1:0]      rd_type
);

  localparam int SIZE_LSB   = RD_LOOP_W;
  localparam int STRIDE_LSB = SIZE_LSB + TX_SIZE_WIDTH;
  localparam int BASE_LSB   = STRIDE_LSB + OFFSET_ADDR_W;
  localparam int TYPE_LSB   = BASE_LSB + BASE_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ROM_ADDR_W:0]      total;
  logic [ROM_ADDR_W:0]      idx;
  logic [ROM_ADDR_W:0]      idx_inc;
  logic [RD_LOOP_W-1:0]     count;
  logic [RD_LOOP_W-1:0]     loop_max_r;
  logic [BASE_ADDR_W-1:0]   base_r;
  logic [OFFSET_ADDR_W-1:0] stride_r;
  logic [ADDR_W-1:0]        offset_r;
  logic [TX_SIZE_WIDTH-1:0] size_r;
  logic [D_TYPE_W-1:0]      type_r;
  logic                     last_req;
  logic                     last_desc;

  assign idx_inc   = idx + (ROM_ADDR_W + 1)'(1);
  // count only reaches loop_max before the compare, so it never wraps
  assign last_req  = (count == loop_max_r);
  assign last_desc = (idx_inc == total);

  assign rd_addr     = ADDR_W'(base_r) + offset_r;
  assign rd_req_size = size_r;
  assign rd_type     = type_r;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_rd_en = 1'b0;
    cfg_addr  = '0;
    rd_req    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (cfg_count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        cfg_rd_en = 1'b1;
        cfg_addr  = idx[ROM_ADDR_W-1:0];
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_ISSUE;
      S_ISSUE: begin
        rd_req = rd_ready;
        if (rd_ready && last_req) state_nxt = last_desc ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A reset cycle must not leak a request or done from the aborted walk
    if (reset) begin
      rd_req    = 1'b0;
      done      = 1'b0;
      cfg_rd_en = 1'b0;
      cfg_addr  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total      <= '0;
      idx        <= '0;
      count      <= '0;
      loop_max_r <= '0;
      base_r     <= '0;
      stride_r   <= '0;
      offset_r   <= '0;
      size_r     <= '0;
      type_r     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && cfg_count != '0) begin
            total <= cfg_count;
            idx   <= '0;
          end
        end
        S_WAIT: begin
          type_r     <= cfg_data[TYPE_LSB +: D_TYPE_W];
          base_r     <= cfg_data[BASE_LSB +: BASE_ADDR_W];
          stride_r   <= cfg_data[STRIDE_LSB +: OFFSET_ADDR_W];
          size_r     <= cfg_data[SIZE_LSB +: TX_SIZE_WIDTH];
          loop_max_r <= cfg_data[0 +: RD_LOOP_W];
          offset_r   <= '0;
          count      <= '0;
        end
        S_ISSUE: begin
          if (rd_ready) begin
            if (last_req) begin
              if (!last_desc) idx <= idx_inc;
            end else begin
              count    <= count + RD_LOOP_W'(1);
              offset_r <= offset_r + ADDR_W'(stride_r);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
